seg_scan_mux: RTL
=================

Name: seg_scan_mux

Overview:
Time-multiplexed scan driver for the two-digit common-anode 7-segment display.
- Consumes the 16-bit active-low segment word produced by seg_decoder: [15:8] is the tens digit, [7:0] is the units digit, bit order a..g,dp with dp at bit 0.
- Drives one shared 8-bit segment bus and two active-low digit enables.
- Adds a snapshot at each frame start (prevents tearing), a dead-time between digits (prevents ghosting), optional leading-zero blanking, and 4-bit PWM brightness.

Parameters:
REFRESH_DIV, 25000, clock cycles in each digit SHOW slot; must be >= 1.
BLANK_CYCLES, 500, clock cycles of dead-time before each SHOW slot; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 forces the display dark
seg_in  in  16  active-low segment word from seg_decoder
lz_blank  in  1  1 = blank the tens digit when its pattern is '0' (8'h03)
brightness  in  4  PWM duty; on-cycles per 16 = brightness+1
seg_out  out  8  active-low shared segment bus
dig_sel  out  2  active-low digit enables; [1] = tens, [0] = units
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.

Reset state:
- seg_out=8'hFF, dig_sel=2'b11, frame_tick=0.
- State is IDLE; all counters are 0.
- snapshot=16'hFFFF; bright_q=0; lz_q=0.

Outputs: all are registered and reflect the state currently held.

FSM states: IDLE, BLANK_T, SHOW_T, BLANK_U, SHOW_U.
- IDLE: en=1 -> BLANK_T. The same edge takes the snapshot (seg_in, brightness, lz_blank) and pulses frame_tick.
- BLANK_T: lasts BLANK_CYCLES cycles, then -> SHOW_T.
- SHOW_T: lasts REFRESH_DIV cycles, then -> BLANK_U.
- BLANK_U: lasts BLANK_CYCLES cycles, then -> SHOW_U.
- SHOW_U: lasts REFRESH_DIV cycles, then -> BLANK_T. This edge also takes the snapshot and pulses frame_tick.
- Frame period is 2*(BLANK_CYCLES+REFRESH_DIV) cycles.

en=0 in any state: on the next edge go to IDLE, seg_out=FF, dig_sel=11, counters cleared. en=1 restarts at BLANK_T with a fresh snapshot.

Outputs by state:
- BLANK_*: seg_out=FF, dig_sel=11.
- SHOW_T, PWM on: seg_out=snapshot[15:8], dig_sel=01.
- SHOW_U, PWM on: seg_out=snapshot[7:0], dig_sel=10.
- PWM off: seg_out=FF, dig_sel=11.

PWM:
- A 4-bit counter clears on entry to each SHOW state and increments every SHOW cycle, wrapping 15 -> 0.
- The digit is on while pwm_cnt <= bright_q.
- brightness=15 gives always on.

Leading-zero blanking: if lz_q=1 and snapshot[15:8]==8'h03, SHOW_T behaves as PWM-off for its whole slot. The units digit is never blanked.

Latency: a change on seg_in, brightness or lz_blank appears no earlier than the next frame boundary. There is no mid-frame update.

Slot counter width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)+1). It counts 0..N-1 and the slot ends when it reaches N-1.

Decomposition:
- Package seg_disp_pkg holds:
  - the state enum;
  - SEG_OFF=8'hFF;
  - DIG_OFF=2'b11;
  - SEG_ZERO=8'h03;
  - DIG_TENS=2'b01 and DIG_UNITS=2'b10.
- One sub-module, seg_slot_timer: a parameterised slot counter with load length, start and done outputs, reused for the blank and show slots.

Test Plan:
(All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, brightness=15, lz_blank=0 unless stated.)
1. Reset and first frame: hold rst_n=0 -> outputs FF/11/0. Release with en=1, seg_in=16'h9F25 ("12"). Required response: frame_tick pulse; 2 cycles of 11; 8 cycles of seg_out=9F, dig_sel=01; 2 cycles of 11; 8 cycles of 25/10; frame_tick repeats every 20 cycles.
2. Snapshot: change seg_in to 16'h0D0D mid-SHOW_T -> the current frame still shows 9F then 25. The next frame shows 0D/0D.
3. Leading-zero blank: seg_in=16'h0349 ("05").
   - lz_blank=1: the tens slot holds dig_sel=11, seg_out=FF for all 8 cycles; the units slot shows 49.
   - lz_blank=0: the tens slot shows 03.
4. Brightness: brightness=3 -> each 8-cycle SHOW slot is digit-on for cycles 0-3 and dark for 4-7. brightness=0 -> on for cycle 0 only.
5. Enable drop: en=0 during SHOW_U -> next edge gives FF/11 and no frame_tick. en=1 again -> frame_tick, BLANK_T, and the new seg_in is shown.
6. Async reset mid-SHOW_T: assert rst_n=0 between clock edges -> seg_out=FF and dig_sel=11 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the two-digit common-anode display scanner.
// Segment and digit values are active-low.
package seg_disp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBlankT,
        StShowT,
        StBlankU,
        StShowU
    } scan_state_e;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [1:0] DIG_OFF   = 2'b11;
    localparam logic [7:0] SEG_ZERO  = 8'h03;
    localparam logic [1:0] DIG_TENS  = 2'b01;
    localparam logic [1:0] DIG_UNITS = 2'b10;

    // Digit is lit for brightness+1 of every 16 SHOW cycles.
    function automatic logic pwm_on(input logic [3:0] cnt, input logic [3:0] bright);
        return (cnt <= bright);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter shared by the blank and show slots: counts 0..len-1 while running,
// restarts on i_start and wraps to 0 at the end of each slot.
module seg_slot_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_run,
    input  logic [W-1:0] i_len,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt == (i_len - W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_start || (i_run && o_done)) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit 7-segment scan driver: per-frame snapshot, dead-time between digits,
// leading-zero blanking and 4-bit PWM brightness. All outputs are registered.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 25000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seg_in,
    input  logic        lz_blank,
    input  logic [3:0]  brightness,
    output logic [7:0]  seg_out,
    output logic [1:0]  dig_sel,
    output logic        frame_tick
);

    localparam int unsigned MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);

    scan_state_e r_state;
    logic [15:0] r_snap;
    logic [3:0]  r_bright;
    logic        r_lz;
    logic [3:0]  r_pwm;
    logic [7:0]  r_seg;
    logic [1:0]  r_dig;
    logic        r_tick;

    logic          w_in_show;
    logic [CW-1:0] w_len;
    logic          w_start;
    logic          w_run;
    logic          w_done;
    logic          w_tens_blank;
    logic [3:0]    w_pwm_nxt;

    assign w_in_show    = (r_state == StShowT) || (r_state == StShowU);
    assign w_len        = w_in_show ? CW'(REFRESH_DIV) : CW'(BLANK_CYCLES);
    assign w_start      = !en || (r_state == StIdle);
    assign w_run        = en && (r_state != StIdle);
    assign w_tens_blank = r_lz && (r_snap[15:8] == SEG_ZERO);
    assign w_pwm_nxt    = r_pwm + 4'd1;

    seg_slot_timer #(
        .W (CW)
    ) u_slot_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_run   (w_run),
        .i_len   (w_len),
        .o_done  (w_done)
    );

    // Outputs are computed from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_snap   <= 16'hFFFF;
            r_bright <= 4'd0;
            r_lz     <= 1'b0;
            r_pwm    <= 4'd0;
            r_seg    <= SEG_OFF;
            r_dig    <= DIG_OFF;
            r_tick   <= 1'b0;
        end else if (!en) begin
            r_state <= StIdle;
            r_pwm   <= 4'd0;
            r_seg   <= SEG_OFF;
            r_dig   <= DIG_OFF;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_seg  <= SEG_OFF;
            r_dig  <= DIG_OFF;
            unique case (r_state)
                StIdle: begin
                    r_state  <= StBlankT;
                    r_snap   <= seg_in;
                    r_bright <= brightness;
                    r_lz     <= lz_blank;
                    r_pwm    <= 4'd0;
                    r_tick   <= 1'b1;
                end
                StBlankT: begin
                    if (w_done) begin
                        r_state <= StShowT;
                        r_pwm   <= 4'd0;
                        if (!w_tens_blank) begin
                            r_seg <= r_snap[15:8];
                            r_dig <= DIG_TENS;
                        end
                    end
                end
                StShowT: begin
                    if (w_done) begin
                        r_state <= StBlankU;
                        r_pwm   <= 4'd0;
                    end else begin
                        r_pwm <= w_pwm_nxt;
                        if (pwm_on(w_pwm_nxt, r_bright) && !w_tens_blank) begin
                            r_seg <= r_snap[15:8];
                            r_dig <= DIG_TENS;
                        end
                    end
                end
                StBlankU: begin
                    if (w_done) begin
                        r_state <= StShowU;
                        r_pwm   <= 4'd0;
                        r_seg   <= r_snap[7:0];
                        r_dig   <= DIG_UNITS;
                    end
                end
                StShowU: begin
                    if (w_done) begin
                        // Frame boundary: the only point where new inputs are captured.
                        r_state  <= StBlankT;
                        r_snap   <= seg_in;
                        r_bright <= brightness;
                        r_lz     <= lz_blank;
                        r_pwm    <= 4'd0;
                        r_tick   <= 1'b1;
                    end else begin
                        r_pwm <= w_pwm_nxt;
                        if (pwm_on(w_pwm_nxt, r_bright)) begin
                            r_seg <= r_snap[7:0];
                            r_dig <= DIG_UNITS;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign seg_out    = r_seg;
    assign dig_sel    = r_dig;
    assign frame_tick = r_tick;

endmodule
